// File: rtl/console_pkg.sv
// Shared definitions for the text console controller.
//   - Default geometry (COLS_DEF, ROWS_DEF, ADDR_W_DEF).
//   - ASCII control codes and the printable range.
//   - FSM state type and the cursor command type.
package console_pkg;

  localparam int COLS_DEF   = 80;
  localparam int ROWS_DEF   = 25;
  localparam int ADDR_W_DEF = 11;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] PRINT_LO    = 8'h20;
  localparam logic [7:0] PRINT_HI    = 8'h7E;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    CUR_HOLD,
    CUR_INC,
    CUR_DEC,
    CUR_NEWLINE,
    CUR_CR,
    CUR_ZERO
  } cursor_cmd_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor tracker for the text console.
//   Keeps row, column and the linear address (row*COLS+col) as parallel
//   counters so no multiplier is needed. Applies all wrap rules.
// Ports:
//   CLK    in   clock
//   RST_N  in   synchronous active-low reset (cursor to 0)
//   cmd    in   cursor command (hold/inc/dec/newline/cr/zero)
//   pos    out  linear cursor address
module console_cursor
  import console_pkg::*;
#(
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  cursor_cmd_t       cmd,
  output logic [ADDR_W-1:0] pos
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      col <= '0;
      row <= '0;
      pos <= '0;
    end else begin
      case (cmd)
        CUR_INC: begin
          if (col == LAST_COL) begin
            col <= '0;
            if (row == LAST_ROW) begin
              row <= '0;
              pos <= '0;
            end else begin
              row <= row + ROW_W'(1);
              pos <= pos + ADDR_W'(1);
            end
          end else begin
            col <= col + COL_W'(1);
            pos <= pos + ADDR_W'(1);
          end
        end
        CUR_DEC: begin
          if (pos != '0) begin
            pos <= pos - ADDR_W'(1);
            if (col == '0) begin
              col <= LAST_COL;
              row <= row - ROW_W'(1);
            end else begin
              col <= col - COL_W'(1);
            end
          end
        end
        CUR_NEWLINE: begin
          col <= '0;
          if (row == LAST_ROW) begin
            row <= '0;
            pos <= '0;
          end else begin
            row <= row + ROW_W'(1);
            // Start of next row = start of this row + COLS.
            pos <= pos - ADDR_W'(col) + ADDR_W'(COLS);
          end
        end
        CUR_CR: begin
          col <= '0;
          pos <= pos - ADDR_W'(col);
        end
        CUR_ZERO: begin
          col <= '0;
          row <= '0;
          pos <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/text_console_ctrl.sv
// Text console write sequencer for a COLS x ROWS character RAM.
//   Accepts bytes over valid/ready, interprets BS/LF/FF/CR, writes printable
//   characters at the cursor, and blank-fills the screen after reset or on
//   clear request.
// Ports:
//   CLK, RST_N            clock, synchronous active-low reset
//   in_char/in_valid      byte from CPU side
//   in_ready              byte accepted when in_valid & in_ready
//   clear_req             full-screen clear request (sampled in IDLE)
//   busy                  high while clearing
//   cursor_pos            linear cursor address
//   write_character_pos   RAM write address (registered)
//   write_character       RAM write data (registered)
//   write_strobe          RAM write enable, one cycle per write
module text_console_ctrl
  import console_pkg::*;
#(
  parameter int         COLS       = COLS_DEF,
  parameter int         ROWS       = ROWS_DEF,
  parameter int         ADDR_W     = ADDR_W_DEF,
  parameter logic [7:0] CLEAR_CHAR = ASCII_SPACE
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [7:0]        in_char,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clear_req,
  output logic              busy,
  output logic [ADDR_W-1:0] cursor_pos,
  output logic [ADDR_W-1:0] write_character_pos,
  output logic [7:0]        write_character,
  output logic              write_strobe
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  cursor_cmd_t       cursor_cmd;
  logic              accept;

  assign in_ready = (state == IDLE) && !clear_req;
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  // Cursor is held at zero for the whole clear so it lands on 0 at exit.
  always_comb begin
    cursor_cmd = CUR_HOLD;
    if (state == CLEAR || clear_req) begin
      cursor_cmd = CUR_ZERO;
    end else if (accept) begin
      if (is_printable(in_char))      cursor_cmd = CUR_INC;
      else if (in_char == ASCII_LF)   cursor_cmd = CUR_NEWLINE;
      else if (in_char == ASCII_CR)   cursor_cmd = CUR_CR;
      else if (in_char == ASCII_BS)   cursor_cmd = CUR_DEC;
      else if (in_char == ASCII_FF)   cursor_cmd = CUR_ZERO;
    end
  end

  console_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .CLK   (CLK),
    .RST_N (RST_N),
    .cmd   (cursor_cmd),
    .pos   (cursor_pos)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state               <= CLEAR;
      clr_addr            <= '0;
      write_strobe        <= 1'b0;
      write_character_pos <= '0;
      write_character     <= '0;
    end else begin
      write_strobe <= 1'b0;
      case (state)
        CLEAR: begin
          write_strobe        <= 1'b1;
          write_character_pos <= clr_addr;
          write_character     <= CLEAR_CHAR;
          if (clr_addr == LAST_CELL) begin
            state    <= IDLE;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        default: begin
          if (clear_req || (accept && in_char == ASCII_FF)) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end else if (accept) begin
            if (is_printable(in_char)) begin
              write_strobe        <= 1'b1;
              write_character_pos <= cursor_pos;
              write_character     <= in_char;
            end else if (in_char == ASCII_BS && cursor_pos != '0) begin
              // Blank the cell the cursor moves back onto.
              write_strobe        <= 1'b1;
              write_character_pos <= cursor_pos - ADDR_W'(1);
              write_character     <= CLEAR_CHAR;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed self-checking bench for text_console_ctrl (80x25, 11-bit address).
module tb_text_console_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        in_valid = 1'b0;
  logic        clear_req = 1'b0;
  logic        in_ready;
  logic        busy;
  logic [10:0] cursor_pos;
  logic [10:0] write_character_pos;
  logic [7:0]  write_character;
  logic        write_strobe;

  int checks = 0;
  int failures = 0;

  text_console_ctrl #(
    .COLS       (80),
    .ROWS       (25),
    .ADDR_W     (11),
    .CLEAR_CHAR (8'h20)
  ) dut (
    .CLK                 (CLK),
    .RST_N               (RST_N),
    .in_char             (in_char),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .clear_req           (clear_req),
    .busy                (busy),
    .cursor_pos          (cursor_pos),
    .write_character_pos (write_character_pos),
    .write_character     (write_character),
    .write_strobe        (write_strobe)
  );

  always #5 CLK = ~CLK;

  // Present one byte for one cycle; outputs are then observed at the negedge
  // following the accepting posedge.
  task automatic send_byte(input logic [7:0] c);
    in_char  = c;
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  // Follow a clear: counts strobes, counts ones whose pos/char break the
  // 0,1,2.. / 8'h20 sequence, and stops when busy drops (bounded).
  task automatic follow_clear(output int n, output int bad, output bit done);
    n = 0; bad = 0; done = 1'b0;
    for (int i = 0; i < 2200; i++) begin
      @(negedge CLK);
      if (write_strobe) begin
        if (write_character_pos !== 11'(n) || write_character !== 8'h20) bad++;
        n++;
      end
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0; in_valid = 1'b0; clear_req = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (write_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe actual=%0b expected=0", write_strobe); end
    checks++; if (write_character_pos !== 11'd0) begin failures++; $display("FAIL reset_pos actual=%0d expected=0", write_character_pos); end
    checks++; if (write_character !== 8'h00) begin failures++; $display("FAIL reset_char actual=%h expected=00", write_character); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy actual=%0b expected=1", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready actual=%0b expected=0", in_ready); end
    checks++; if (cursor_pos !== 11'd0) begin failures++; $display("FAIL reset_cursor actual=%0d expected=0", cursor_pos); end
    RST_N = 1'b1;
  endtask

  task automatic test_initial_clear;
    int n, bad; bit done;
    follow_clear(n, bad, done);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL init_clear_timeout actual=%0b expected=1", done); end
    checks++; if (n != 2000) begin failures++; $display("FAIL init_clear_count actual=%0d expected=2000", n); end
    checks++; if (bad != 0) begin failures++; $display("FAIL init_clear_seq bad=%0d expected=0", bad); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL init_clear_ready actual=%0b expected=1", in_ready); end
    checks++; if (cursor_pos !== 11'd0) begin failures++; $display("FAIL init_clear_cursor actual=%0d expected=0", cursor_pos); end
    @(negedge CLK);
    checks++; if (write_strobe !== 1'b0) begin failures++; $display("FAIL init_clear_stop actual=%0b expected=0", write_strobe); end
  endtask

  task automatic test_back_to_back;
    in_char = 8'h41; in_valid = 1'b1;
    @(negedge CLK);
    checks++; if (write_strobe !== 1'b1 || write_character_pos !== 11'd0 || write_character !== 8'h41) begin
      failures++; $display("FAIL b2b_A actual=%0b/%0d/%h expected=1/0/41", write_strobe, write_character_pos, write_character); end
    in_char = 8'h42;
    @(negedge CLK);
    in_valid = 1'b0;
    checks++; if (write_strobe !== 1'b1 || write_character_pos !== 11'd1 || write_character !== 8'h42) begin
      failures++; $display("FAIL b2b_B actual=%0b/%0d/%h expected=1/1/42", write_strobe, write_character_pos, write_character); end
    checks++; if (cursor_pos !== 11'd2) begin failures++; $display("FAIL b2b_cursor actual=%0d expected=2", cursor_pos); end
  endtask

  task automatic test_cr_lf;
    send_byte(8'h0D);
    checks++; if (write_strobe !== 1'b0 || cursor_pos !== 11'd0) begin
      failures++; $display("FAIL cr_home actual=%0b/%0d expected=0/0", write_strobe, cursor_pos); end
    send_byte(8'h58);
    send_byte(8'h59);
    checks++; if (write_character_pos !== 11'd1 || write_character !== 8'h59 || cursor_pos !== 11'd2) begin
      failures++; $display("FAIL xy actual=%0d/%h/%0d expected=1/59/2", write_character_pos, write_character, cursor_pos); end
    send_byte(8'h0D);
    checks++; if (write_strobe !== 1'b0 || cursor_pos !== 11'd0) begin
      failures++; $display("FAIL cr actual=%0b/%0d expected=0/0", write_strobe, cursor_pos); end
    send_byte(8'h0A);
    checks++; if (write_strobe !== 1'b0 || cursor_pos !== 11'd80) begin
      failures++; $display("FAIL lf actual=%0b/%0d expected=0/80", write_strobe, cursor_pos); end
  endtask

  task automatic test_backspace;
    int n, bad; bit done;
    send_byte(8'h0C);
    checks++; if (busy !== 1'b1 || cursor_pos !== 11'd0) begin
      failures++; $display("FAIL ff_enter actual=%0b/%0d expected=1/0", busy, cursor_pos); end
    follow_clear(n, bad, done);
    checks++; if (!done || n != 2000 || bad != 0) begin
      failures++; $display("FAIL ff_clear actual=%0b/%0d/%0d expected=1/2000/0", done, n, bad); end
    @(negedge CLK);
    send_byte(8'h08);
    checks++; if (write_strobe !== 1'b0 || cursor_pos !== 11'd0) begin
      failures++; $display("FAIL bs_at_zero actual=%0b/%0d expected=0/0", write_strobe, cursor_pos); end
    send_byte(8'h51);
    checks++; if (write_strobe !== 1'b1 || write_character !== 8'h51 || cursor_pos !== 11'd1) begin
      failures++; $display("FAIL bs_q actual=%0b/%h/%0d expected=1/51/1", write_strobe, write_character, cursor_pos); end
    send_byte(8'h08);
    checks++; if (write_strobe !== 1'b1 || write_character_pos !== 11'd0 || write_character !== 8'h20) begin
      failures++; $display("FAIL bs_write actual=%0b/%0d/%h expected=1/0/20", write_strobe, write_character_pos, write_character); end
    checks++; if (cursor_pos !== 11'd0) begin failures++; $display("FAIL bs_cursor actual=%0d expected=0", cursor_pos); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 80; i++) send_byte(8'h61 + 8'(i % 26));
    checks++; if (write_character_pos !== 11'd79 || cursor_pos !== 11'd80) begin
      failures++; $display("FAIL row_wrap actual=%0d/%0d expected=79/80", write_character_pos, cursor_pos); end
    for (int i = 0; i < 23; i++) send_byte(8'h0A);
    checks++; if (cursor_pos !== 11'd1920) begin failures++; $display("FAIL lf_to_row24 actual=%0d expected=1920", cursor_pos); end
    send_byte(8'h0A);
    checks++; if (write_strobe !== 1'b0 || cursor_pos !== 11'd0) begin
      failures++; $display("FAIL lf_last_row actual=%0b/%0d expected=0/0", write_strobe, cursor_pos); end
    for (int i = 0; i < 24; i++) send_byte(8'h0A);
    for (int i = 0; i < 79; i++) send_byte(8'h2E);
    checks++; if (cursor_pos !== 11'd1999) begin failures++; $display("FAIL reach_1999 actual=%0d expected=1999", cursor_pos); end
    send_byte(8'h01);
    checks++; if (write_strobe !== 1'b0 || cursor_pos !== 11'd1999) begin
      failures++; $display("FAIL other_byte actual=%0b/%0d expected=0/1999", write_strobe, cursor_pos); end
    send_byte(8'h5A);
    checks++; if (write_strobe !== 1'b1 || write_character_pos !== 11'd1999 || write_character !== 8'h5A) begin
      failures++; $display("FAIL last_cell actual=%0b/%0d/%h expected=1/1999/5a", write_strobe, write_character_pos, write_character); end
    checks++; if (cursor_pos !== 11'd0) begin failures++; $display("FAIL screen_wrap actual=%0d expected=0", cursor_pos); end
  endtask

  task automatic test_clear_priority;
    int n, bad, ready_seen; bit done, found;
    @(negedge CLK);
    in_char = 8'h4B; in_valid = 1'b1; clear_req = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL prio_ready actual=%0b expected=0", in_ready); end
    @(negedge CLK);
    clear_req = 1'b0;
    checks++; if (busy !== 1'b1 || write_strobe !== 1'b0) begin
      failures++; $display("FAIL prio_enter actual=%0b/%0b expected=1/0", busy, write_strobe); end
    found = 1'b0; ready_seen = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge CLK);
      if (in_ready) ready_seen++;
      if (write_strobe && write_character_pos == 11'd999) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found || ready_seen != 0) begin
      failures++; $display("FAIL prio_mid_clear actual=%0b/%0d expected=1/0", found, ready_seen); end
    RST_N = 1'b0;
    @(negedge CLK);
    checks++; if (write_strobe !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL mid_reset actual=%0b/%0b/%0b expected=0/1/0", write_strobe, busy, in_ready); end
    RST_N = 1'b1;
    follow_clear(n, bad, done);
    checks++; if (!done || n != 2000 || bad != 0) begin
      failures++; $display("FAIL restart_clear actual=%0b/%0d/%0d expected=1/2000/0", done, n, bad); end
    @(negedge CLK);
    in_valid = 1'b0;
    checks++; if (write_strobe !== 1'b1 || write_character_pos !== 11'd0 || write_character !== 8'h4B) begin
      failures++; $display("FAIL held_byte actual=%0b/%0d/%h expected=1/0/4b", write_strobe, write_character_pos, write_character); end
    checks++; if (cursor_pos !== 11'd1) begin failures++; $display("FAIL held_cursor actual=%0d expected=1", cursor_pos); end
  endtask

  initial begin
    test_reset;
    test_initial_clear;
    test_back_to_back;
    test_cr_lf;
    test_backspace;
    test_wrap;
    test_clear_priority;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
